// File: rtl/lcd_spi_arbiter.sv
// Round-robin / lockable arbiter in front of the single SPI byte writer of the 12864 LCD path.
// Requesters: 0 = init sequencer, 1 = draw engine, 2 = clear/fill engine.
module lcd_spi_arbiter #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [2:0] Req_Sig,
  input  logic [2:0] Lock_Sig,
  input  logic [8:0] Req_Data_0,
  input  logic [8:0] Req_Data_1,
  input  logic [8:0] Req_Data_2,
  output logic [2:0] Grant_Sig,
  output logic [2:0] Byte_Done_Sig,
  output logic [2:0] Err_Sig,
  output logic       SPI_Start_Sig,
  output logic [8:0] SPI_Data,
  input  logic       SPI_Done_Sig
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  done_q, done_d;
  logic [2:0]  err_q, err_d;
  logic        start_q, start_d;
  logic [8:0]  data_q, data_d;
  logic [15:0] wd_q, wd_d;
  logic [7:0]  gap_q, gap_d;
  logic        abort_q, abort_d;

  logic       sel_vld;
  logic [1:0] sel_idx;
  logic [8:0] sel_data;
  logic [8:0] owner_data;
  logic       owner_keep;

  // Round-robin pick: first requester after the last winner, wrapping.
  always_comb begin
    sel_vld = |Req_Sig;
    case (rr_q)
      2'd0:    sel_idx = Req_Sig[1] ? 2'd1 : (Req_Sig[2] ? 2'd2 : 2'd0);
      2'd1:    sel_idx = Req_Sig[2] ? 2'd2 : (Req_Sig[0] ? 2'd0 : 2'd1);
      default: sel_idx = Req_Sig[0] ? 2'd0 : (Req_Sig[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    case (sel_idx)
      2'd0:    sel_data = Req_Data_0;
      2'd1:    sel_data = Req_Data_1;
      default: sel_data = Req_Data_2;
    endcase
  end

  assign owner_data = ({9{grant_q[0]}} & Req_Data_0)
                    | ({9{grant_q[1]}} & Req_Data_1)
                    | ({9{grant_q[2]}} & Req_Data_2);

  // A locked owner keeps the bus only if the previous byte was not aborted.
  assign owner_keep = !abort_q && (|(grant_q & Lock_Sig)) && (|(grant_q & Req_Sig));

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    start_d = start_q;
    data_d  = data_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    abort_d = abort_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          grant_d = 3'b001 << sel_idx;
          data_d  = sel_data;
          start_d = 1'b1;
          rr_d    = sel_idx;
          wd_d    = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (SPI_Done_Sig) begin
          start_d = 1'b0;
          done_d  = grant_q;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (WD_EN && wd_q == WD_LAST) begin
          start_d = 1'b0;
          err_d   = grant_q;
          abort_d = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (WD_EN) begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_GAP: begin
        if (GAP_CYCLES == 0 || gap_q == GAP_LAST) begin
          abort_d = 1'b0;
          if (owner_keep) begin
            data_d  = owner_data;
            start_d = 1'b1;
            wd_d    = '0;
            state_d = S_SEND;
          end else begin
            grant_d = '0;
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      rr_q    <= 2'd2;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
    end
  end

  assign Grant_Sig     = grant_q;
  assign Byte_Done_Sig = done_q;
  assign Err_Sig       = err_q;
  assign SPI_Start_Sig = start_q;
  assign SPI_Data      = data_q;

endmodule

// File: doc/lcd_spi_arbiter.md
Name: lcd_spi_arbiter

Overview:
- Shares the single SPI byte-writer of the 12864 LCD path between three requesters: 0 = init sequencer, 1 = draw engine, 2 = clear/fill engine.
- Arbitrates round-robin per byte, or holds the bus across multi-byte sequences when the owner asserts Lock.
- Latches the owner's byte and DC flag, drives the SPI writer with a level-held start, and returns a one-cycle done pulse to the owner.
- Watchdog aborts a transfer that never completes.

Parameters:
- GAP_CYCLES, 2, idle cycles inserted after every byte before the next start (CS recovery); range 0..255.
- TIMEOUT_CYCLES, 1023, max cycles in SEND without SPI_Done_Sig before abort; 0 disables the watchdog; 16-bit counter.

Ports:
- CLK  in  1  system clock
- RSTn  in  1  reset
- Req_Sig  in  3  per-requester byte request; level, held until that requester's Byte_Done/Err
- Lock_Sig  in  3  per-requester bus lock; keeps grant across consecutive bytes
- Req_Data_0  in  9  requester 0 {DC, byte[7:0]}; DC=0 command, 1 data
- Req_Data_1  in  9  requester 1 {DC, byte}
- Req_Data_2  in  9  requester 2 {DC, byte}
- Grant_Sig  out  3  one-hot current owner
- Byte_Done_Sig  out  3  one-cycle pulse to owner: byte sent
- Err_Sig  out  3  one-cycle pulse to owner: watchdog abort
- SPI_Start_Sig  out  1  start level to SPI writer, held until SPI_Done_Sig
- SPI_Data  out  9  latched {DC, byte} to SPI writer
- SPI_Done_Sig  in  1  SPI writer completion pulse

Behaviour:
- Reset: RSTn asynchronous, active-low; clock CLK. All outputs 0; state IDLE; rr pointer = 2 (requester 0 has first priority); counters 0.
- Reset mid-transfer: immediate abort, no done or error pulse. The SPI writer is reset by the same RSTn.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any Req_Sig bit is high, select the first set bit searching from (rr+1) mod 3 upward with wrap.
  - At the next edge: Grant_Sig = one-hot(sel), SPI_Data = Req_Data_sel, SPI_Start_Sig = 1, rr = sel, go SEND.
  - Latency: Req sampled at edge n, start visible after edge n (one cycle).
- SEND:
  - SPI_Start_Sig and SPI_Data are stable.
  - On SPI_Done_Sig = 1: SPI_Start_Sig <= 0, Byte_Done_Sig[owner] <= 1 for exactly one cycle, go GAP.
  - Watchdog (TIMEOUT_CYCLES > 0): counts cycles in SEND. If count reaches TIMEOUT_CYCLES with no SPI_Done_Sig: SPI_Start_Sig <= 0, Err_Sig[owner] pulses one cycle, lock is cleared, go GAP. The watchdog counter clears on entering SEND.
  - SPI_Done_Sig in the same cycle as timeout expiry: done wins, no error.
  - An owner dropping Req_Sig or Lock_Sig during SEND is ignored; the byte completes.
- GAP:
  - Grant_Sig is held. Count GAP_CYCLES; GAP_CYCLES = 0 means GAP lasts one cycle (the decision cycle only).
  - At the end: if Lock_Sig[owner] and Req_Sig[owner] are both high (no abort occurred), reload SPI_Data from the owner, assert SPI_Start_Sig, stay granted, go SEND. No arbitration; rr unchanged.
  - Otherwise Grant_Sig <= 0 and go IDLE. Re-arbitration happens from IDLE, costing one extra cycle.
  - Lock high with Req low releases the bus (no deadlock).
- Requester contract: Req_Data stable while Req is high and ungranted. After Byte_Done, the requester may change data and keep Req high to send the next byte.
- SPI_Done_Sig outside SEND is ignored.
- Grant_Sig is always one-hot or zero. Byte_Done_Sig and Err_Sig are never high simultaneously.

Test Plan:
- Reset then Req=3'b001, data 9'h0AE; SPI writer model answers Done 5 cycles after start. Required: start one cycle after Req; SPI_Data = 0x0AE; Byte_Done[0] one pulse; grant released after 2 gap cycles.
- Req=3'b111 held continuously, no lock. Required: byte grant order 0,1,2,0,1,2; every start separated by ≥ GAP_CYCLES+1 idle cycles.
- Req1+Lock1 high for 4 bytes (0x140,0x1FF,0x100,0x181) while Req0 is also high. Required: 4 consecutive grants to requester 1 in order; requester 0 served only after Lock1 drops.
- SPI model never returns Done, TIMEOUT_CYCLES = 20. Required: start held 20 cycles then dropped; Err[owner] pulses; no Byte_Done; lock cleared; next requester served.
- Done arriving exactly on the timeout cycle. Required: Byte_Done pulse, no Err.
- RSTn asserted mid-SEND. Required: all outputs 0 asynchronously; after release, Req0 is served first.
